// File: rtl/shift_serializer.sv
// shift_serializer
// Parallel-to-serial output stage. A single holding register lets the
// producer hand over the next word while the current word is still being
// shifted out. Each frame is DATA_WIDTH consecutive valid bits, marked by
// frame_start on the first bit and frame_done on the last bit. GAP_CYCLES
// idle cycles can be forced between frames. Every serial output is a
// registered flop.
module shift_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  msb_first,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  frame_start,
    output logic                  frame_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state, state_next;

    // Holding register: the word waiting for the serial line.
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_msb;
    logic                  hold_full;

    // Shifter: the word currently on the serial line.
    logic [DATA_WIDTH-1:0] shift_data;
    logic                  shift_msb;
    logic [CNT_W-1:0]      bit_cnt;
    logic [3:0]            gap_cnt;

    // Control decoded by the state machine for the current cycle.
    logic load_shift;
    logic bit_inc;
    logic gap_clr;
    logic gap_inc;
    logic emit;
    logic accept;
    logic bit_sel;

    // The holding register is free whenever it is empty and reset is low.
    assign in_ready = ~hold_full & ~reset;
    assign accept   = in_valid & in_ready;

    // Bit presented this cycle: index bit_cnt from the LSB or from the MSB.
    assign bit_sel = shift_msb ? shift_data[BIT_LAST - bit_cnt]
                               : shift_data[bit_cnt];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control decode.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        load_shift = 1'b0;
        bit_inc    = 1'b0;
        gap_clr    = 1'b0;
        gap_inc    = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load_shift = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                emit = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    if (GAP_CYCLES > 0) begin
                        gap_clr    = 1'b1;
                        state_next = GAP;
                    end else if (hold_full) begin
                        // Back-to-back: next frame follows with no idle cycle.
                        load_shift = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_inc = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (hold_full) begin
                        load_shift = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding register: filled on a handshake, emptied on transfer to the
    // shifter. The two never coincide because in_ready is low while full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_msb  <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= in_data;
            hold_msb  <= msb_first;
        end else if (load_shift) begin
            hold_full <= 1'b0;
        end
    end

    // Shifter word and bit order, reloaded from the holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_data <= '0;
            shift_msb  <= 1'b0;
        end else if (load_shift) begin
            shift_data <= hold_data;
            shift_msb  <= hold_msb;
        end
    end

    // Bit counter: restarts on each load, steps once per emitted bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (load_shift) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Gap counter: counts forced idle cycles between frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (gap_clr) begin
            gap_cnt <= '0;
        end else if (gap_inc) begin
            gap_cnt <= gap_cnt + 4'd1;
        end
    end

    // Registered serial outputs; data and markers are forced low when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            ser_out     <= emit & bit_sel;
            ser_valid   <= emit;
            frame_start <= emit & (bit_cnt == '0);
            frame_done  <= emit & (bit_cnt == BIT_LAST);
        end
    end

endmodule
